// File: rtl/tile_game_controller_pkg.sv
// Shared types and constants for the Piano Tiles round controller.
package tile_game_controller_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } game_state_t;

    localparam int NUM_LANES = 4;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_F     = 8'h09;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [9:0]  SPAWN_Y_DEF   = 10'd0;
    localparam logic [9:0]  HIT_TOP_DEF   = 10'd370;
    localparam logic [9:0]  HIT_BOT_DEF   = 10'd399;
    localparam logic [10:0] KILL_Y_DEF    = 11'd400;
    localparam logic [5:0]  SPAWN_GAP_DEF = 6'd60;
    localparam logic [1:0]  MAX_LIVES_DEF = 2'd3;
    localparam logic [7:0]  LFSR_SEED     = 8'hA5;

    function automatic logic [7:0] lane_key(input int lane);
        logic [7:0] k;
        k = KEY_A;
        case (lane)
            1:       k = KEY_S;
            2:       k = KEY_D;
            3:       k = KEY_F;
            default: k = KEY_A;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/tile_game_controller_if.sv
// Keyboard/frame inputs and tile/score outputs of the round controller.
interface tile_game_controller_if;
    import tile_game_controller_pkg::*;

    logic                     frame_clk;
    logic [7:0]               keycode;
    logic [3:0]               speed;
    logic [10*NUM_LANES-1:0]  tile_y;
    logic [NUM_LANES-1:0]     tile_active;
    logic [7:0]               score;
    logic [1:0]               lives;
    game_state_t              game_state;

    modport master (
        output frame_clk, keycode, speed,
        input  tile_y, tile_active, score, lives, game_state
    );

    modport slave (
        input  frame_clk, keycode, speed,
        output tile_y, tile_active, score, lives, game_state
    );

endinterface

// File: rtl/tile_game_controller_lane_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick spawn lanes.
module tile_game_controller_lane_lfsr
    import tile_game_controller_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/tile_game_controller.sv
// Piano Tiles round sequencer: game FSM, tile spawn/motion, hit judgement, score and lives.
module tile_game_controller
    import tile_game_controller_pkg::*;
#(
    parameter logic [9:0]  SPAWN_Y   = SPAWN_Y_DEF,
    parameter logic [9:0]  HIT_TOP   = HIT_TOP_DEF,
    parameter logic [9:0]  HIT_BOT   = HIT_BOT_DEF,
    parameter logic [10:0] KILL_Y    = KILL_Y_DEF,
    parameter logic [5:0]  SPAWN_GAP = SPAWN_GAP_DEF,
    parameter logic [1:0]  MAX_LIVES = MAX_LIVES_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    tile_game_controller_if.slave  bus
);

    game_state_t          r_state, w_state_next;
    logic                 r_frame_q;
    logic [7:0]           r_key_q;
    logic [9:0]           r_tile_y [NUM_LANES];
    logic [9:0]           w_tile_y_next [NUM_LANES];
    logic [NUM_LANES-1:0] r_active, w_active_next;
    logic [7:0]           r_score, w_score_next;
    logic [1:0]           r_lives, w_lives_next;
    logic [5:0]           r_spawn_cnt, w_spawn_cnt_next;

    logic [7:0]           w_lfsr;
    logic [1:0]           w_spawn_lane;
    logic                 w_unused_lfsr;
    logic                 w_frame_tick, w_play, w_space_edge, w_enter_play;
    logic                 w_spawn_due, w_spawn_ok;
    logic [3:0]           w_speed_eff, w_score_inc, w_loss;
    logic [8:0]           w_score_sum;
    logic [NUM_LANES-1:0] w_hit, w_pen, w_miss;

    tile_game_controller_lane_lfsr u_lfsr (
        .Clk    (Clk),
        .Reset  (Reset),
        .o_lfsr (w_lfsr)
    );

    assign w_spawn_lane  = w_lfsr[1:0];
    assign w_unused_lfsr = ^w_lfsr[7:2];

    assign w_frame_tick = bus.frame_clk & ~r_frame_q;
    assign w_space_edge = (bus.keycode == KEY_SPACE) && (r_key_q != KEY_SPACE);
    assign w_play       = (r_state == StPlay);
    assign w_enter_play = (r_state == StIdle) && w_space_edge;
    assign w_speed_eff  = (bus.speed == 4'd0) ? 4'd1 : bus.speed;
    assign w_score_inc  = 4'd1 + {2'b00, w_speed_eff[3:2]};
    assign w_score_sum  = {1'b0, r_score} + {5'd0, w_score_inc};

    // A busy target lane leaves the counter saturated so the spawn retries next tick.
    assign w_spawn_due = (r_spawn_cnt >= SPAWN_GAP);
    assign w_spawn_ok  = w_play && w_frame_tick && w_spawn_due && !r_active[w_spawn_lane];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic        w_key_edge, w_in_win, w_spawn_here, w_act_nxt;
        logic [9:0]  w_y_nxt;
        logic [10:0] w_sum;

        assign w_key_edge   = w_play && (bus.keycode == lane_key(l)) && (r_key_q != lane_key(l));
        assign w_in_win     = r_active[l] && (r_tile_y[l] >= HIT_TOP) && (r_tile_y[l] <= HIT_BOT);
        assign w_hit[l]     = w_key_edge && w_in_win;
        assign w_pen[l]     = w_key_edge && !w_in_win;
        assign w_spawn_here = w_spawn_ok && (w_spawn_lane == 2'(l));
        assign w_sum        = {1'b0, r_tile_y[l]} + {7'd0, w_speed_eff};
        // Hit is judged on the pre-move position, so a hit tile cannot also be a miss.
        assign w_miss[l]    = w_play && w_frame_tick && r_active[l] && !w_hit[l] && (w_sum > KILL_Y);

        always_comb begin
            w_act_nxt = r_active[l];
            w_y_nxt   = r_tile_y[l];
            if (w_enter_play) begin
                w_act_nxt = 1'b0;
            end else if (w_hit[l]) begin
                w_act_nxt = 1'b0;
            end else if (w_spawn_here) begin
                w_act_nxt = 1'b1;
                w_y_nxt   = SPAWN_Y;
            end else if (w_play && w_frame_tick && r_active[l]) begin
                w_y_nxt = w_sum[9:0];
                if (w_miss[l]) begin
                    w_act_nxt = 1'b0;
                end
            end
        end

        assign w_active_next[l]        = w_act_nxt;
        assign w_tile_y_next[l]        = w_y_nxt;
        assign bus.tile_y[10*l +: 10]  = r_tile_y[l];
    end

    always_comb begin
        w_loss = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_loss = w_loss + {3'd0, w_miss[i]} + {3'd0, w_pen[i]};
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_score_next     = r_score;
        w_lives_next     = r_lives;
        w_spawn_cnt_next = r_spawn_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_space_edge) begin
                    w_state_next     = StPlay;
                    w_score_next     = 8'd0;
                    w_lives_next     = MAX_LIVES;
                    w_spawn_cnt_next = SPAWN_GAP;
                end
            end
            StPlay: begin
                if (r_lives == 2'd0) begin
                    w_state_next = StOver;
                end
                if (|w_hit) begin
                    w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                end
                w_lives_next = ({2'b00, r_lives} > w_loss) ? (r_lives - w_loss[1:0]) : 2'd0;
                if (w_frame_tick) begin
                    if (!w_spawn_due) begin
                        w_spawn_cnt_next = r_spawn_cnt + 6'd1;
                    end else if (w_spawn_ok) begin
                        w_spawn_cnt_next = 6'd0;
                    end
                end
            end
            StOver: begin
                if (w_space_edge) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_frame_q   <= 1'b0;
            r_key_q     <= 8'd0;
            r_tile_y    <= '{default: '0};
            r_active    <= '0;
            r_score     <= 8'd0;
            r_lives     <= MAX_LIVES;
            r_spawn_cnt <= 6'd0;
        end else begin
            r_state     <= w_state_next;
            r_frame_q   <= bus.frame_clk;
            r_key_q     <= bus.keycode;
            r_tile_y    <= w_tile_y_next;
            r_active    <= w_active_next;
            r_score     <= w_score_next;
            r_lives     <= w_lives_next;
            r_spawn_cnt <= w_spawn_cnt_next;
        end
    end

    assign bus.tile_active = r_active;
    assign bus.score       = r_score;
    assign bus.lives       = r_lives;
    assign bus.game_state  = r_state;

endmodule

// File: tb/tb_tile_game_controller.sv
// Directed bench for tile_game_controller: reset, spawn, hit, miss, game over, saturation.
module tb_tile_game_controller;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] m_lfsr;

    tile_game_controller_if bus ();

    tile_game_controller dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent LFSR reference (x^8+x^6+x^5+x^4+1, seed A5) to predict spawn lanes.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [7:0] key_for(input int lane);
        logic [7:0] k;
        case (lane)
            1:       k = 8'h16;
            2:       k = 8'h07;
            3:       k = 8'h09;
            default: k = 8'h04;
        endcase
        return k;
    endfunction

    function automatic logic [9:0] y_of(input int lane);
        return bus.tile_y[lane*10 +: 10];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'd0;
        bus.speed     = 4'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) bus.frame_clk = 1'b1;
        @(negedge clk) bus.frame_clk = 1'b0;
    endtask

    task automatic tick_capture(output int lane);
        @(negedge clk);
        bus.frame_clk = 1'b1;
        lane = int'(m_lfsr[1:0]);
        @(negedge clk) bus.frame_clk = 1'b0;
    endtask

    task automatic tick_on_lane(input int lane);
        int n = 0;
        @(negedge clk);
        while (m_lfsr[1:0] != 2'(lane) && n < 64) begin
            @(negedge clk);
            n++;
        end
        bus.frame_clk = 1'b1;
        @(negedge clk) bus.frame_clk = 1'b0;
    endtask

    task automatic press(input logic [7:0] key);
        @(negedge clk) bus.keycode = key;
        @(negedge clk) bus.keycode = 8'd0;
    endtask

    task automatic start_play();
        press(8'h2C);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
        repeat (10) tick();
        n_checks++; if (bus.game_state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d want 0", bus.game_state); end
        n_checks++; if (bus.tile_active !== 4'd0) begin n_fail++; $display("FAIL idle_active: got %b want 0000", bus.tile_active); end
        n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL idle_score: got %0d want 0", bus.score); end
        n_checks++; if (bus.lives !== 2'd3) begin n_fail++; $display("FAIL idle_lives: got %0d want 3", bus.lives); end
        n_checks++; if (bus.tile_y !== 40'd0) begin n_fail++; $display("FAIL idle_tile_y: got %h want 0", bus.tile_y); end
    endtask

    task automatic test_start_spawn();
        int lane;
        do_reset();
        bus.speed = 4'd0;
        @(negedge clk) bus.keycode = 8'h2C;
        @(negedge clk);
        n_checks++; if (bus.game_state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", bus.game_state); end
        bus.keycode = 8'd0;
        tick_capture(lane);
        n_checks++; if (bus.tile_active !== 4'(1 << lane)) begin n_fail++; $display("FAIL first_spawn: got %b want lane %0d", bus.tile_active, lane); end
        n_checks++; if (y_of(lane) !== 10'd0) begin n_fail++; $display("FAIL spawn_y: got %0d want 0", y_of(lane)); end
        repeat (60) tick();
        n_checks++; if (bus.tile_active !== 4'(1 << lane)) begin n_fail++; $display("FAIL spawn_gap: got %b want lane %0d only", bus.tile_active, lane); end
        n_checks++; if (y_of(lane) !== 10'd60) begin n_fail++; $display("FAIL speed0_motion: got %0d want 60", y_of(lane)); end
    endtask

    task automatic test_hit();
        do_reset();
        start_play();
        bus.speed = 4'd10;
        tick_on_lane(0);
        n_checks++; if (bus.tile_active !== 4'b0001) begin n_fail++; $display("FAIL hit_spawn: got %b want 0001", bus.tile_active); end
        repeat (38) tick();
        n_checks++; if (y_of(0) !== 10'd380) begin n_fail++; $display("FAIL hit_pos: got %0d want 380", y_of(0)); end
        @(negedge clk) bus.keycode = 8'h04;
        @(negedge clk);
        n_checks++; if (bus.tile_active[0] !== 1'b0) begin n_fail++; $display("FAIL hit_clear: got %b want 0", bus.tile_active[0]); end
        n_checks++; if (bus.score !== 8'd3) begin n_fail++; $display("FAIL hit_score: got %0d want 3", bus.score); end
        repeat (5) tick();
        n_checks++; if (bus.score !== 8'd3) begin n_fail++; $display("FAIL hold_score: got %0d want 3", bus.score); end
        n_checks++; if (bus.lives !== 2'd3) begin n_fail++; $display("FAIL hold_lives: got %0d want 3", bus.lives); end
        bus.keycode = 8'd0;
    endtask

    task automatic test_miss();
        int lane;
        do_reset();
        start_play();
        bus.speed = 4'd10;
        tick_capture(lane);
        repeat (39) tick();
        bus.speed = 4'd8;
        tick();
        n_checks++; if (y_of(lane) !== 10'd398) begin n_fail++; $display("FAIL miss_pos: got %0d want 398", y_of(lane)); end
        bus.speed = 4'd5;
        tick();
        n_checks++; if (bus.tile_active[lane] !== 1'b0) begin n_fail++; $display("FAIL miss_clear: got %b want 0", bus.tile_active[lane]); end
        n_checks++; if (bus.lives !== 2'd2) begin n_fail++; $display("FAIL miss_lives: got %0d want 2", bus.lives); end
    endtask

    task automatic test_penalty_over();
        do_reset();
        start_play();
        bus.speed = 4'd5;
        tick_on_lane(2);
        repeat (40) tick();
        n_checks++; if (y_of(2) !== 10'd200) begin n_fail++; $display("FAIL pen_pos: got %0d want 200", y_of(2)); end
        press(8'h07);
        n_checks++; if (bus.lives !== 2'd2) begin n_fail++; $display("FAIL pen_lives: got %0d want 2", bus.lives); end
        n_checks++; if (bus.tile_active !== 4'b0100) begin n_fail++; $display("FAIL pen_active: got %b want 0100", bus.tile_active); end
        press(8'h07);
        press(8'h07);
        n_checks++; if (bus.lives !== 2'd0) begin n_fail++; $display("FAIL pen_lives0: got %0d want 0", bus.lives); end
        @(negedge clk);
        n_checks++; if (bus.game_state !== 2'd2) begin n_fail++; $display("FAIL over_state: got %0d want 2", bus.game_state); end
        repeat (3) tick();
        n_checks++; if (y_of(2) !== 10'd200 || bus.tile_active !== 4'b0100) begin
            n_fail++; $display("FAIL over_frozen: got y=%0d act=%b want y=200 act=0100", y_of(2), bus.tile_active);
        end
        press(8'h2C);
        n_checks++; if (bus.game_state !== 2'd0) begin n_fail++; $display("FAIL over_to_idle: got %0d want 0", bus.game_state); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        start_play();
        press(8'h2C);
        n_checks++; if (bus.game_state !== 2'd1) begin n_fail++; $display("FAIL space_in_play: got %0d want 1", bus.game_state); end
        bus.speed = 4'd15;
        tick_on_lane(0);
        repeat (26) tick();
        bus.speed = 4'd9;
        tick();
        n_checks++; if (y_of(0) !== 10'd399) begin n_fail++; $display("FAIL same_pos: got %0d want 399", y_of(0)); end
        bus.speed = 4'd4;
        @(negedge clk);
        bus.frame_clk = 1'b1;
        bus.keycode   = 8'h04;
        @(negedge clk);
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'd0;
        n_checks++; if (bus.tile_active[0] !== 1'b0) begin n_fail++; $display("FAIL same_clear: got %b want 0", bus.tile_active[0]); end
        n_checks++; if (bus.score !== 8'd2) begin n_fail++; $display("FAIL same_score: got %0d want 2", bus.score); end
        n_checks++; if (bus.lives !== 2'd3) begin n_fail++; $display("FAIL same_lives: got %0d want 3", bus.lives); end
    endtask

    task automatic hit_round(input logic [3:0] hit_speed, output bit ok);
        int n = 0;
        int lane = 0;
        ok = 1'b0;
        bus.speed = 4'd15;
        while (bus.tile_active == 4'd0 && n < 100) begin
            tick();
            n++;
        end
        if (bus.tile_active != 4'd0) begin
            for (int i = 0; i < 4; i++) if (bus.tile_active[i]) lane = i;
            repeat (25) tick();
            bus.speed = hit_speed;
            press(key_for(lane));
            ok = 1'b1;
        end
    endtask

    // Continues from test_same_cycle with score 2: 63 hits of +4 reach 254, then +2 saturates.
    task automatic test_saturate();
        bit ok;
        int n_ok = 0;
        for (int r = 0; r < 63; r++) begin
            hit_round(4'd15, ok);
            if (ok) n_ok++;
        end
        n_checks++; if (bus.score !== 8'd254) begin n_fail++; $display("FAIL score_254: got %0d want 254", bus.score); end
        hit_round(4'd4, ok);
        if (ok) n_ok++;
        n_checks++; if (bus.score !== 8'd255) begin n_fail++; $display("FAIL score_sat: got %0d want 255", bus.score); end
        n_checks++; if (n_ok !== 64) begin n_fail++; $display("FAIL sat_rounds: got %0d spawns want 64", n_ok); end
        n_checks++; if (bus.lives !== 2'd3) begin n_fail++; $display("FAIL sat_lives: got %0d want 3", bus.lives); end
    endtask

    initial begin
        test_reset();
        test_start_spawn();
        test_hit();
        test_miss();
        test_penalty_over();
        test_same_cycle();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
